// File: rtl/dmr_obi_lockstep_checker_if.sv
// rtl/dmr_obi_lockstep_checker_if.sv - dual-core data-request ports plus shared bus grant
interface dmr_obi_lockstep_checker_if;
    logic        c0_req_i;
    logic [31:0] c0_addr_i;
    logic        c0_we_i;
    logic [3:0]  c0_be_i;
    logic [31:0] c0_wdata_i;
    logic        c1_req_i;
    logic [31:0] c1_addr_i;
    logic        c1_we_i;
    logic [3:0]  c1_be_i;
    logic [31:0] c1_wdata_i;
    logic        gnt_i;

    modport master (
        output c0_req_i, c0_addr_i, c0_we_i, c0_be_i, c0_wdata_i,
        output c1_req_i, c1_addr_i, c1_we_i, c1_be_i, c1_wdata_i,
        output gnt_i
    );

    modport slave (
        input c0_req_i, c0_addr_i, c0_we_i, c0_be_i, c0_wdata_i,
        input c1_req_i, c1_addr_i, c1_we_i, c1_be_i, c1_wdata_i,
        input gnt_i
    );
endinterface

// File: rtl/dmr_obi_lockstep_checker.sv
// rtl/dmr_obi_lockstep_checker.sv - lockstep checker buffering master requests until the shadow core replays them
module dmr_obi_lockstep_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          master_sel_i,
    input  logic                          clear_i,
    dmr_obi_lockstep_checker_if.slave     bus,
    output logic                          mismatch_o,
    output logic                          error_o,
    output logic [1:0]                    err_code_o,
    output logic [ERR_CNT_W-1:0]          err_count_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_TRACK    = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } tuple_t;

    // Write data only matters for writes; reads may carry stale wdata.
    function automatic logic tuple_eq(input tuple_t a, input tuple_t b);
        return (a.addr == b.addr) && (a.we == b.we) && (a.be == b.be) &&
               (!a.we || (a.wdata == b.wdata));
    endfunction

    logic [1:0]       state_q;
    logic             ms_q;
    tuple_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic [AGE_W-1:0] age_q;

    tuple_t c0_t, c1_t, m_t, s_t, head_t;
    logic   m_req, s_req, tracking, m_hs, s_hs, empty, full;
    logic   do_push, do_pop, cmp_fail, ovf, tmo, err_event;
    logic [1:0] new_code;

    assign c0_t     = '{addr: bus.c0_addr_i, we: bus.c0_we_i, be: bus.c0_be_i, wdata: bus.c0_wdata_i};
    assign c1_t     = '{addr: bus.c1_addr_i, we: bus.c1_we_i, be: bus.c1_be_i, wdata: bus.c1_wdata_i};
    assign m_t      = ms_q ? c1_t : c0_t;
    assign s_t      = ms_q ? c0_t : c1_t;
    assign m_req    = ms_q ? bus.c1_req_i : bus.c0_req_i;
    assign s_req    = ms_q ? bus.c0_req_i : bus.c1_req_i;
    assign tracking = (state_q == ST_TRACK) && enable_i;
    assign m_hs     = tracking && m_req && bus.gnt_i;
    assign s_hs     = tracking && s_req && bus.gnt_i;
    assign empty    = (count_q == '0);
    assign full     = (count_q == LVL_FULL);
    assign head_t   = mem[rd_ptr_q];

    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        cmp_fail = 1'b0;
        ovf      = 1'b0;
        tmo      = 1'b0;
        if (m_hs && s_hs) begin
            if (empty) begin
                cmp_fail = !tuple_eq(m_t, s_t);
            end else begin
                do_pop   = 1'b1;
                do_push  = 1'b1;
                cmp_fail = !tuple_eq(head_t, s_t);
            end
        end else if (m_hs) begin
            if (full) ovf = 1'b1;
            else      do_push = 1'b1;
        end else if (s_hs) begin
            if (empty) begin
                ovf = 1'b1;
            end else begin
                do_pop   = 1'b1;
                cmp_fail = !tuple_eq(head_t, s_t);
            end
        end
        if (tracking && !empty && !do_pop && (age_q >= AGE_LIMIT)) tmo = 1'b1;
    end

    assign err_event = cmp_fail || tmo || ovf;
    assign new_code  = cmp_fail ? 2'd1 : (tmo ? 2'd2 : 2'd3);

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= m_t;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_DISABLED;
            ms_q     <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
        end else begin
            case (state_q)
                ST_TRACK: begin
                    if (!enable_i || err_event) begin
                        // Both exits discard whatever the shadow has not yet replayed.
                        state_q  <= enable_i ? ST_ERROR : ST_DISABLED;
                        rd_ptr_q <= '0;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                        age_q    <= '0;
                    end else begin
                        if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        if (do_push && !do_pop)      count_q <= count_q + LVL_W'(1);
                        else if (do_pop && !do_push) count_q <= count_q - LVL_W'(1);
                        age_q <= (empty || do_pop) ? '0 : age_q + AGE_W'(1);
                    end
                end
                ST_ERROR: begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                    age_q    <= '0;
                    if (clear_i) begin
                        state_q <= enable_i ? ST_TRACK : ST_DISABLED;
                        if (enable_i) ms_q <= master_sel_i;
                    end else if (!enable_i) begin
                        state_q <= ST_DISABLED;
                    end
                end
                default: begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                    age_q    <= '0;
                    if (enable_i) begin
                        state_q <= ST_TRACK;
                        ms_q    <= master_sel_i;
                    end else begin
                        state_q <= ST_DISABLED;
                    end
                end
            endcase
        end
    end

    // A clear and a fresh error in the same cycle leave only the fresh error recorded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mismatch_o  <= 1'b0;
            error_o     <= 1'b0;
            err_code_o  <= 2'd0;
            err_count_o <= '0;
        end else begin
            mismatch_o <= err_event;
            if (clear_i) begin
                error_o     <= err_event;
                err_code_o  <= err_event ? new_code : 2'd0;
                err_count_o <= err_event ? ERR_CNT_W'(1) : '0;
            end else if (err_event) begin
                error_o <= 1'b1;
                if (err_code_o == 2'd0) err_code_o <= new_code;
                if (err_count_o != '1)  err_count_o <= err_count_o + ERR_CNT_W'(1);
            end
        end
    end

    assign fifo_level_o = count_q;

endmodule
